// File: rtl/line_write_buffer_if.sv
// Line-level memory port bundle: upstream cache-controller side plus downstream
// main-memory side of the write buffer, and the occupancy count.
interface line_write_buffer_if #(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned ADDR_LEN      = 9,
  parameter int unsigned DEPTH         = 4
);
  localparam int unsigned LineW = 32 * (1 << LINE_ADDR_LEN);
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;

  logic [ADDR_LEN-1:0] up_addr;
  logic                up_rd_req;
  logic                up_wr_req;
  logic [LineW-1:0]    up_wr_line;
  logic [LineW-1:0]    up_rd_line;
  logic                up_gnt;

  logic [ADDR_LEN-1:0] mem_addr;
  logic                mem_rd_req;
  logic                mem_wr_req;
  logic [LineW-1:0]    mem_wr_line;
  logic [LineW-1:0]    mem_rd_line;
  logic                mem_gnt;

  logic [CntW-1:0]     wb_count;

  // The buffer itself.
  modport slave (
    input  up_addr, up_rd_req, up_wr_req, up_wr_line, mem_rd_line, mem_gnt,
    output up_rd_line, up_gnt, mem_addr, mem_rd_req, mem_wr_req, mem_wr_line, wb_count
  );

  // Cache controller plus main memory, seen from outside the buffer.
  modport master (
    output up_addr, up_rd_req, up_wr_req, up_wr_line, mem_rd_line, mem_gnt,
    input  up_rd_line, up_gnt, mem_addr, mem_rd_req, mem_wr_req, mem_wr_line, wb_count
  );
endinterface

// File: rtl/line_write_buffer.sv
// Line write-back buffer: absorbs dirty-line writes into a small circular FIFO,
// drains them to main memory in the background, coalesces repeated writes to a
// queued line and forwards buffered data to read hits. Reads that miss go to
// memory ahead of any pending drain.
module line_write_buffer #(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned ADDR_LEN      = 9,
  parameter int unsigned DEPTH         = 4
) (
  input logic                 clk,
  input logic                 rst,
  line_write_buffer_if.slave  bus
);
  localparam int unsigned LineW = 32 * (1 << LINE_ADDR_LEN);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  localparam logic [1:0] U_IDLE  = 2'd0;
  localparam logic [1:0] U_WAIT  = 2'd1;
  localparam logic [1:0] U_ACK   = 2'd2;

  localparam logic [1:0] D_IDLE  = 2'd0;
  localparam logic [1:0] D_READ  = 2'd1;
  localparam logic [1:0] D_WRITE = 2'd2;

  logic [DEPTH-1:0]    r_valid;
  logic [ADDR_LEN-1:0] r_addr [DEPTH];
  logic [LineW-1:0]    r_line [DEPTH];
  logic [PtrW-1:0]     r_head;
  logic [PtrW-1:0]     r_tail;
  logic [CntW-1:0]     r_count;
  logic [1:0]          r_ustate;
  logic [1:0]          r_dstate;
  logic                r_rd_pending;
  logic [ADDR_LEN-1:0] r_rd_addr;
  logic [LineW-1:0]    r_up_rd_line;

  logic [1:0]          w_ustate_d;
  logic [1:0]          w_dstate_d;
  logic [PtrW-1:0]     w_scan_idx;
  logic                w_rd_hit;
  logic [PtrW-1:0]     w_rd_idx;
  logic                w_coal_hit;
  logic [PtrW-1:0]     w_coal_idx;
  logic                w_in_flight;
  logic                w_pop;
  logic                w_rd_done;
  logic                w_rd_miss;
  logic                w_rd_hit_go;
  logic                w_wr_go;
  logic                w_coal;
  logic                w_enq;
  logic [ADDR_LEN-1:0] w_mem_addr;
  logic                w_mem_rd_req;
  logic                w_mem_wr_req;
  logic [LineW-1:0]    w_mem_wr_line;

  assign w_in_flight = (r_dstate == D_WRITE);
  assign w_pop       = w_in_flight && bus.mem_gnt;
  assign w_rd_done   = (r_dstate == D_READ) && bus.mem_gnt;

  // Address match scan from head to tail; later matches override, so the read
  // result is the youngest copy. The in-flight head never takes a coalesce.
  always_comb begin
    w_scan_idx = '0;
    w_rd_hit   = 1'b0;
    w_rd_idx   = '0;
    w_coal_hit = 1'b0;
    w_coal_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_scan_idx = r_head + PtrW'(k);
      if (r_valid[w_scan_idx] && (r_addr[w_scan_idx] == bus.up_addr)) begin
        w_rd_hit = 1'b1;
        w_rd_idx = w_scan_idx;
        if (!(w_in_flight && (w_scan_idx == r_head))) begin
          w_coal_hit = 1'b1;
          w_coal_idx = w_scan_idx;
        end
      end
    end
  end

  // Upstream request decode; a read wins when both requests are high.
  assign w_rd_miss   = (r_ustate == U_IDLE) && bus.up_rd_req && !w_rd_hit;
  assign w_rd_hit_go = (r_ustate == U_IDLE) && bus.up_rd_req && w_rd_hit;
  assign w_wr_go     = (r_ustate == U_IDLE) && !bus.up_rd_req && bus.up_wr_req;
  assign w_coal      = w_wr_go && w_coal_hit;
  // Full check uses the pre-pop count so tail never lands on the slot being popped.
  assign w_enq       = w_wr_go && !w_coal_hit && (r_count < CntW'(DEPTH));

  // Upstream FSM next state.
  always_comb begin
    w_ustate_d = r_ustate;
    case (r_ustate)
      U_IDLE: begin
        if (bus.up_rd_req) begin
          w_ustate_d = w_rd_hit ? U_ACK : U_WAIT;
        end else if (w_coal || w_enq) begin
          w_ustate_d = U_ACK;
        end
      end
      U_WAIT:  if (w_rd_done) w_ustate_d = U_ACK;
      U_ACK:   w_ustate_d = U_IDLE;
      default: w_ustate_d = U_IDLE;
    endcase
  end

  // Downstream FSM next state; a fresh miss is taken straight from idle so it
  // is not queued behind a drain that starts in the same cycle.
  always_comb begin
    w_dstate_d = r_dstate;
    case (r_dstate)
      D_IDLE: begin
        if (r_rd_pending || w_rd_miss) begin
          w_dstate_d = D_READ;
        end else if (r_count != '0) begin
          w_dstate_d = D_WRITE;
        end
      end
      D_READ:  if (bus.mem_gnt) w_dstate_d = D_IDLE;
      D_WRITE: if (bus.mem_gnt) w_dstate_d = D_IDLE;
      default: w_dstate_d = D_IDLE;
    endcase
  end

  // State registers for both FSMs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ustate <= U_IDLE;
      r_dstate <= D_IDLE;
    end else begin
      r_ustate <= w_ustate_d;
      r_dstate <= w_dstate_d;
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_line[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PtrW'(1);
      end
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= bus.up_addr;
        r_line[r_tail]  <= bus.up_wr_line;
        r_tail          <= r_tail + PtrW'(1);
      end
      if (w_coal) begin
        r_line[w_coal_idx] <= bus.up_wr_line;
      end
      r_count <= r_count + CntW'(w_enq) - CntW'(w_pop);
    end
  end

  // Read bookkeeping: pending miss address and the returned line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pending <= 1'b0;
      r_rd_addr    <= '0;
      r_up_rd_line <= '0;
    end else begin
      if (w_rd_miss) begin
        r_rd_pending <= 1'b1;
        r_rd_addr    <= bus.up_addr;
      end
      if (w_rd_hit_go) begin
        r_up_rd_line <= r_line[w_rd_idx];
      end
      if (w_rd_done) begin
        r_up_rd_line <= bus.mem_rd_line;
        r_rd_pending <= 1'b0;
      end
    end
  end

  // Downstream outputs decode from the state; zero whenever idle.
  always_comb begin
    w_mem_addr    = '0;
    w_mem_rd_req  = 1'b0;
    w_mem_wr_req  = 1'b0;
    w_mem_wr_line = '0;
    case (r_dstate)
      D_READ: begin
        w_mem_rd_req = 1'b1;
        w_mem_addr   = r_rd_addr;
      end
      D_WRITE: begin
        w_mem_wr_req  = 1'b1;
        w_mem_addr    = r_addr[r_head];
        w_mem_wr_line = r_line[r_head];
      end
      default: ;
    endcase
  end

  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_rd_req  = w_mem_rd_req;
  assign bus.mem_wr_req  = w_mem_wr_req;
  assign bus.mem_wr_line = w_mem_wr_line;
  assign bus.up_gnt      = (r_ustate == U_ACK);
  assign bus.up_rd_line  = r_up_rd_line;
  assign bus.wb_count    = r_count;

endmodule

// File: tb/tb_line_write_buffer.sv
// Directed bench for line_write_buffer: a vector table of line reads/writes
// against a behavioural memory, then hand-written multi-cycle sequences.
module tb_line_write_buffer;
  localparam int unsigned LineW = 256;

  typedef struct {
    bit               is_rd;
    logic [8:0]       addr;
    logic [LineW-1:0] wline;
    logic [LineW-1:0] exp_line;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_write_buffer_if #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .DEPTH(4)) lwb_if ();

  line_write_buffer #(.LINE_ADDR_LEN(3), .ADDR_LEN(9), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (lwb_if)
  );

  int               n_pass = 0;
  int               n_total = 0;
  logic [LineW-1:0] mem [512];
  bit               mem_en = 1'b0;
  int               mem_lat = 0;
  logic [9:0]       log_q [$];
  int               cyc = 0;
  int               rd_req_cyc = 0;
  int               wr_req_cyc = 0;
  int               last_rd_gnt_cyc = 0;
  int               last_up_gnt_cyc = 0;

  function automatic logic [LineW-1:0] mk_line(input int unsigned seed);
    logic [LineW-1:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = seed * 16 + i;
    return l;
  endfunction

  function automatic logic [LineW-1:0] pattern(input logic [8:0] a);
    return mk_line(32'h1000 + 32'(a));
  endfunction

  task automatic check(input string name, input logic [LineW-1:0] act,
                       input logic [LineW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Behavioural main memory: grants after mem_lat idle cycles when enabled.
  initial begin
    int lat = 0;
    lwb_if.mem_gnt = 1'b0;
    lwb_if.mem_rd_line = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        lwb_if.mem_gnt = 1'b0;
        lat = 0;
      end else if (lwb_if.mem_gnt) begin
        lwb_if.mem_gnt = 1'b0;
      end else if (mem_en && (lwb_if.mem_rd_req || lwb_if.mem_wr_req)) begin
        if (lat >= mem_lat) begin
          lat = 0;
          lwb_if.mem_gnt = 1'b1;
          if (lwb_if.mem_wr_req) begin
            mem[lwb_if.mem_addr] = lwb_if.mem_wr_line;
            log_q.push_back({1'b0, lwb_if.mem_addr});
          end else begin
            lwb_if.mem_rd_line = mem[lwb_if.mem_addr];
            log_q.push_back({1'b1, lwb_if.mem_addr});
          end
        end else begin
          lat++;
        end
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (lwb_if.mem_rd_req) rd_req_cyc++;
    if (lwb_if.mem_wr_req) wr_req_cyc++;
    if (lwb_if.mem_gnt && lwb_if.mem_rd_req) last_rd_gnt_cyc = cyc;
    if (lwb_if.up_gnt) last_up_gnt_cyc = cyc;
  end

  task automatic start_req(input bit is_rd, input logic [8:0] a, input logic [LineW-1:0] l);
    @(posedge clk); #1;
    lwb_if.up_addr    = a;
    lwb_if.up_wr_line = l;
    lwb_if.up_rd_req  = is_rd;
    lwb_if.up_wr_req  = !is_rd;
  endtask

  task automatic wait_gnt(input int max, output bit ok, output int lat);
    ok = 1'b0;
    lat = 0;
    for (int i = 1; i <= max && !ok; i++) begin
      @(negedge clk);
      if (lwb_if.up_gnt) begin
        ok = 1'b1;
        lat = i;
      end
    end
  endtask

  task automatic end_req();
    @(posedge clk); #1;
    lwb_if.up_rd_req = 1'b0;
    lwb_if.up_wr_req = 1'b0;
  endtask

  task automatic do_op(input string name, input bit is_rd, input logic [8:0] a,
                       input logic [LineW-1:0] l, output logic [LineW-1:0] rdata,
                       output int lat);
    bit ok;
    start_req(is_rd, a, l);
    wait_gnt(40, ok, lat);
    rdata = lwb_if.up_rd_line;
    if (!ok) check({name, "_gnt_timeout"}, 0, 1);
    end_req();
  endtask

  task automatic wait_empty(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      ok = (lwb_if.wb_count == 0) && !lwb_if.mem_wr_req && !lwb_if.mem_rd_req;
    end
    check({name, "_drained"}, 256'(ok), 1);
  endtask

  function automatic logic [9:0] log_at(input int idx);
    return (idx < log_q.size()) ? log_q[idx] : 10'h3FF;
  endfunction

  initial begin
    vec_t             vecs [10];
    logic [LineW-1:0] rdata;
    int               lat;
    int               n0;
    int               snap_rd;
    int               snap_wr;
    int               n012;
    bit               ok;
    bit               seen;

    vecs[0] = '{1'b0, 9'h012, mk_line(1), '0};
    vecs[1] = '{1'b1, 9'h012, '0, mk_line(1)};
    vecs[2] = '{1'b1, 9'h055, '0, pattern(9'h055)};
    vecs[3] = '{1'b0, 9'h055, mk_line(2), '0};
    vecs[4] = '{1'b0, 9'h066, mk_line(3), '0};
    vecs[5] = '{1'b1, 9'h055, '0, mk_line(2)};
    vecs[6] = '{1'b1, 9'h066, '0, mk_line(3)};
    vecs[7] = '{1'b0, 9'h055, mk_line(4), '0};
    vecs[8] = '{1'b1, 9'h055, '0, mk_line(4)};
    vecs[9] = '{1'b1, 9'h1FF, '0, pattern(9'h1FF)};

    lwb_if.up_addr = '0;
    lwb_if.up_rd_req = 1'b0;
    lwb_if.up_wr_req = 1'b0;
    lwb_if.up_wr_line = '0;
    for (int a = 0; a < 512; a++) mem[a] = pattern(9'(a));

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_up_gnt", 256'(lwb_if.up_gnt), 0);
    check("rst_up_rd_line", lwb_if.up_rd_line, 0);
    check("rst_mem_rd_req", 256'(lwb_if.mem_rd_req), 0);
    check("rst_mem_wr_req", 256'(lwb_if.mem_wr_req), 0);
    check("rst_mem_addr", 256'(lwb_if.mem_addr), 0);
    check("rst_mem_wr_line", lwb_if.mem_wr_line, 0);
    check("rst_wb_count", 256'(lwb_if.wb_count), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Vector table with a slow-ish memory.
    mem_en = 1'b1;
    mem_lat = 1;
    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].is_rd, vecs[i].addr, vecs[i].wline, rdata, lat);
      if (vecs[i].is_rd) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_line);
    end
    wait_empty("vec");
    check("vec_mem_055", mem[9'h055], mk_line(4));
    check("vec_mem_066", mem[9'h066], mk_line(3));
    mem_lat = 0;

    // Single write, then background drain.
    mem_en = 1'b0;
    do_op("a_wr", 1'b0, 9'h012, mk_line(0), rdata, lat);
    check("a_lat", 256'(lat), 2);
    check("a_count", 256'(lwb_if.wb_count), 1);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      seen = lwb_if.mem_wr_req;
    end
    check("a_wr_req", 256'(seen), 1);
    check("a_mem_addr", 256'(lwb_if.mem_addr), 256'h012);
    check("a_mem_wr_line", lwb_if.mem_wr_line, mk_line(0));
    mem_en = 1'b1;
    wait_empty("a");
    check("a_mem", mem[9'h012], mk_line(0));

    // Coalesce behind an in-flight drain.
    mem_en = 1'b0;
    do_op("b_wr0", 1'b0, 9'h0F0, mk_line(5), rdata, lat);
    repeat (3) @(posedge clk);
    n0 = log_q.size();
    do_op("b_wr1", 1'b0, 9'h012, mk_line(6), rdata, lat);
    check("b_count1", 256'(lwb_if.wb_count), 2);
    do_op("b_wr2", 1'b0, 9'h012, mk_line(7), rdata, lat);
    check("b_count2", 256'(lwb_if.wb_count), 2);
    mem_en = 1'b1;
    wait_empty("b");
    check("b_mem", mem[9'h012], mk_line(7));
    n012 = 0;
    for (int i = n0; i < log_q.size(); i++) if (log_q[i] == {1'b0, 9'h012}) n012++;
    check("b_single_drain", 256'(n012), 1);

    // Read hit forwarded from the buffer.
    mem_en = 1'b0;
    do_op("c_wr", 1'b0, 9'h034, mk_line(8), rdata, lat);
    snap_rd = rd_req_cyc;
    do_op("c_rd", 1'b1, 9'h034, '0, rdata, lat);
    check("c_lat", 256'(lat), 2);
    check("c_rdata", rdata, mk_line(8));
    check("c_no_mem_rd", 256'(rd_req_cyc - snap_rd), 0);
    mem_en = 1'b1;
    wait_empty("c");

    // Full stall and pointer wrap.
    mem_en = 1'b0;
    n0 = log_q.size();
    for (int i = 0; i < 4; i++) begin
      do_op($sformatf("d_wr%0d", i), 1'b0, 9'h0A0 + 9'(i), mk_line(16 + i), rdata, lat);
      check($sformatf("d_lat%0d", i), 256'(lat), 2);
    end
    check("d_count_full", 256'(lwb_if.wb_count), 4);
    start_req(1'b0, 9'h0A4, mk_line(20));
    wait_gnt(6, ok, lat);
    check("d_stalled", 256'(ok), 0);
    check("d_count_stall", 256'(lwb_if.wb_count), 4);
    mem_en = 1'b1;
    wait_gnt(20, ok, lat);
    check("d_5th_gnt", 256'(ok), 1);
    end_req();
    wait_empty("d");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("d_order%0d", i), 256'(log_at(n0 + i)), 256'({1'b0, 9'h0A0 + 9'(i)}));
      check($sformatf("d_mem%0d", i), mem[9'h0A0 + 9'(i)], mk_line(16 + i));
    end

    // Read miss overtakes queued drains.
    mem_en = 1'b0;
    n0 = log_q.size();
    for (int i = 0; i < 3; i++)
      do_op($sformatf("e_wr%0d", i), 1'b0, 9'h0B0 + 9'(i), mk_line(32 + i), rdata, lat);
    check("e_count", 256'(lwb_if.wb_count), 3);
    start_req(1'b1, 9'h100, '0);
    wait_gnt(4, ok, lat);
    check("e_rd_waits", 256'(ok), 0);
    mem_en = 1'b1;
    wait_gnt(30, ok, lat);
    rdata = lwb_if.up_rd_line;
    check("e_rd_gnt", 256'(ok), 1);
    end_req();
    check("e_rdata", rdata, pattern(9'h100));
    check("e_gnt_delay", 256'(last_up_gnt_cyc - last_rd_gnt_cyc), 1);
    wait_empty("e");
    check("e_order0", 256'(log_at(n0)), 256'({1'b0, 9'h0B0}));
    check("e_order1", 256'(log_at(n0 + 1)), 256'({1'b1, 9'h100}));
    check("e_order2", 256'(log_at(n0 + 2)), 256'({1'b0, 9'h0B1}));
    check("e_order3", 256'(log_at(n0 + 3)), 256'({1'b0, 9'h0B2}));

    // Reset during a drain discards the buffer.
    mem_en = 1'b0;
    do_op("f_wr0", 1'b0, 9'h0C0, mk_line(40), rdata, lat);
    do_op("f_wr1", 1'b0, 9'h0C1, mk_line(41), rdata, lat);
    @(negedge clk);
    check("f_draining", 256'(lwb_if.mem_wr_req), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("f_wr_req_drop", 256'(lwb_if.mem_wr_req), 0);
    check("f_count", 256'(lwb_if.wb_count), 0);
    @(posedge clk); #1 rst = 1'b0;
    mem_en = 1'b1;
    snap_rd = rd_req_cyc;
    snap_wr = wr_req_cyc;
    repeat (10) @(negedge clk);
    check("f_quiet", 256'((rd_req_cyc - snap_rd) + (wr_req_cyc - snap_wr)), 0);
    check("f_mem_untouched", mem[9'h0C0], pattern(9'h0C0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
